// File: rtl/pixel_msg_gen.sv
// rtl/pixel_msg_gen.sv - camera emulator producing DN pixel messages with FVAL/LVAL framing
module pixel_msg_gen #(
    parameter int XB_SIZE      = 32,
    parameter int DN_SIZE      = 12,
    parameter int N_COL_MAX    = 2048,
    parameter int N_ROW_MAX    = 2064,
    parameter int GAP_W        = 8,
    parameter int N_FRAME_SIZE = 20,
    localparam int COL_W       = $clog2(N_COL_MAX) + 1,
    localparam int ROW_W       = $clog2(N_ROW_MAX) + 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    input  logic                    stop,
    input  logic [COL_W-1:0]        cfg_n_col,
    input  logic [ROW_W-1:0]        cfg_n_row,
    input  logic [GAP_W-1:0]        cfg_ilg,
    input  logic [GAP_W-1:0]        cfg_ifg,
    input  logic [N_FRAME_SIZE-1:0] cfg_n_frame,
    input  logic                    msg_full,
    output logic                    msg_valid,
    output logic [XB_SIZE-1:0]      msg,
    output logic                    busy,
    output logic                    done,
    output logic [N_FRAME_SIZE-1:0] n_frame,
    output logic                    cfg_err
);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_IFG_PRE = 3'd1;
    localparam logic [2:0] S_LINE    = 3'd2;
    localparam logic [2:0] S_ILG     = 3'd3;
    localparam logic [2:0] S_IFG     = 3'd4;
    localparam logic [2:0] S_DONE    = 3'd5;

    localparam logic [COL_W-1:0] COL_MAX_V = COL_W'(N_COL_MAX);
    localparam logic [ROW_W-1:0] ROW_MAX_V = ROW_W'(N_ROW_MAX);

    logic [2:0]              state_q, state_d;
    logic [COL_W-1:0]        ncol_last_q, ncol_last_d;
    logic [ROW_W-1:0]        nrow_last_q, nrow_last_d;
    logic [GAP_W-1:0]        ilg_last_q, ilg_last_d;
    logic [GAP_W-1:0]        ifg_last_q, ifg_last_d;
    logic [N_FRAME_SIZE-1:0] nfr_cfg_q, nfr_cfg_d;
    logic [COL_W-1:0]        col_q, col_d;
    logic [ROW_W-1:0]        row_q, row_d;
    logic [DN_SIZE-1:0]      frame_q, frame_d;
    logic [GAP_W-1:0]        gap_q, gap_d;
    logic [N_FRAME_SIZE-1:0] n_frame_q, n_frame_d;
    logic                    stop_pend_q, stop_pend_d;
    logic                    busy_q, busy_d;
    logic                    done_q, done_d;
    logic                    cfg_err_q, cfg_err_d;
    logic                    msg_valid_q, msg_valid_d;
    logic [XB_SIZE-1:0]      msg_q, msg_d;

    logic                    cfg_ok;
    logic [DN_SIZE-1:0]      dn;

    function automatic logic [XB_SIZE-1:0] make_word(input logic fval,
                                                     input logic lval,
                                                     input logic [DN_SIZE-1:0] dn_v);
        logic [XB_SIZE-1:0] w;
        w              = '0;
        w[4]           = lval;
        w[5]           = fval;
        w[8 +: DN_SIZE] = dn_v;
        return w;
    endfunction

    assign cfg_ok = (cfg_n_col != '0) && (cfg_n_col <= COL_MAX_V) &&
                    (cfg_n_row != '0) && (cfg_n_row <= ROW_MAX_V);

    // DN counters only matter modulo 2^DN_SIZE, so truncating before the add is exact
    assign dn = frame_q + DN_SIZE'(row_q) + DN_SIZE'(col_q);

    always_comb begin
        state_d     = state_q;
        ncol_last_d = ncol_last_q;
        nrow_last_d = nrow_last_q;
        ilg_last_d  = ilg_last_q;
        ifg_last_d  = ifg_last_q;
        nfr_cfg_d   = nfr_cfg_q;
        col_d       = col_q;
        row_d       = row_q;
        frame_d     = frame_q;
        gap_d       = gap_q;
        n_frame_d   = n_frame_q;
        stop_pend_d = stop_pend_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        cfg_err_d   = cfg_err_q;
        msg_valid_d = 1'b0;
        msg_d       = msg_q;

        if (busy_q && stop) begin
            stop_pend_d = 1'b1;
        end

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (cfg_ok) begin
                        ncol_last_d = cfg_n_col - 1'b1;
                        nrow_last_d = cfg_n_row - 1'b1;
                        // a zero gap length behaves as a single word
                        ilg_last_d  = (cfg_ilg == '0) ? '0 : cfg_ilg - 1'b1;
                        ifg_last_d  = (cfg_ifg == '0) ? '0 : cfg_ifg - 1'b1;
                        nfr_cfg_d   = cfg_n_frame;
                        col_d       = '0;
                        row_d       = '0;
                        frame_d     = '0;
                        gap_d       = '0;
                        n_frame_d   = '0;
                        stop_pend_d = 1'b0;
                        busy_d      = 1'b1;
                        state_d     = S_IFG_PRE;
                    end else begin
                        cfg_err_d = 1'b1;
                    end
                end
            end
            S_DONE: begin
                done_d      = 1'b1;
                busy_d      = 1'b0;
                stop_pend_d = 1'b0;
                state_d     = S_IDLE;
            end
            default: begin
                if (!msg_full) begin
                    msg_valid_d = 1'b1;
                    case (state_q)
                        S_IFG_PRE: begin
                            msg_d = make_word(1'b0, 1'b0, '0);
                            if (gap_q == ifg_last_q) begin
                                gap_d   = '0;
                                col_d   = '0;
                                state_d = S_LINE;
                            end else begin
                                gap_d = gap_q + 1'b1;
                            end
                        end
                        S_LINE: begin
                            msg_d = make_word(1'b1, 1'b1, dn);
                            if (col_q == ncol_last_q) begin
                                col_d = '0;
                                if (row_q == nrow_last_q) begin
                                    n_frame_d = n_frame_q + 1'b1;
                                    state_d   = S_IFG;
                                end else begin
                                    state_d = S_ILG;
                                end
                            end else begin
                                col_d = col_q + 1'b1;
                            end
                        end
                        S_ILG: begin
                            msg_d = make_word(1'b1, 1'b0, '0);
                            if (gap_q == ilg_last_q) begin
                                gap_d   = '0;
                                row_d   = row_q + 1'b1;
                                state_d = S_LINE;
                            end else begin
                                gap_d = gap_q + 1'b1;
                            end
                        end
                        S_IFG: begin
                            msg_d = make_word(1'b0, 1'b0, '0);
                            if (gap_q == ifg_last_q) begin
                                gap_d = '0;
                                if (((nfr_cfg_q != '0) && (n_frame_q == nfr_cfg_q)) ||
                                    stop_pend_q || stop) begin
                                    state_d = S_DONE;
                                end else begin
                                    row_d   = '0;
                                    frame_d = frame_q + 1'b1;
                                    state_d = S_LINE;
                                end
                            end else begin
                                gap_d = gap_q + 1'b1;
                            end
                        end
                        default: begin
                            msg_valid_d = 1'b0;
                            busy_d      = 1'b0;
                            state_d     = S_IDLE;
                        end
                    endcase
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            ncol_last_q <= '0;
            nrow_last_q <= '0;
            ilg_last_q  <= '0;
            ifg_last_q  <= '0;
            nfr_cfg_q   <= '0;
            col_q       <= '0;
            row_q       <= '0;
            frame_q     <= '0;
            gap_q       <= '0;
            n_frame_q   <= '0;
            stop_pend_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            cfg_err_q   <= 1'b0;
            msg_valid_q <= 1'b0;
            msg_q       <= '0;
        end else begin
            state_q     <= state_d;
            ncol_last_q <= ncol_last_d;
            nrow_last_q <= nrow_last_d;
            ilg_last_q  <= ilg_last_d;
            ifg_last_q  <= ifg_last_d;
            nfr_cfg_q   <= nfr_cfg_d;
            col_q       <= col_d;
            row_q       <= row_d;
            frame_q     <= frame_d;
            gap_q       <= gap_d;
            n_frame_q   <= n_frame_d;
            stop_pend_q <= stop_pend_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            cfg_err_q   <= cfg_err_d;
            msg_valid_q <= msg_valid_d;
            msg_q       <= msg_d;
        end
    end

    assign msg_valid = msg_valid_q;
    assign msg       = msg_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign n_frame   = n_frame_q;
    assign cfg_err   = cfg_err_q;

endmodule

// File: tb/tb_pixel_msg_gen.sv
// tb/tb_pixel_msg_gen.sv - scoreboard bench for pixel_msg_gen
module tb_pixel_msg_gen;

    localparam int COL_W = $clog2(8192) + 1;
    localparam int ROW_W = $clog2(2064) + 1;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic              start = 1'b0;
    logic              stop = 1'b0;
    logic [COL_W-1:0]  cfg_n_col = '0;
    logic [ROW_W-1:0]  cfg_n_row = '0;
    logic [7:0]        cfg_ilg = '0;
    logic [7:0]        cfg_ifg = '0;
    logic [19:0]       cfg_n_frame = '0;
    logic              msg_full = 1'b0;
    logic              msg_valid;
    logic [31:0]       msg;
    logic              busy;
    logic              done;
    logic [19:0]       n_frame;
    logic              cfg_err;

    pixel_msg_gen #(.N_COL_MAX(8192)) dut (
        .clk(clk), .reset(reset), .start(start), .stop(stop),
        .cfg_n_col(cfg_n_col), .cfg_n_row(cfg_n_row), .cfg_ilg(cfg_ilg),
        .cfg_ifg(cfg_ifg), .cfg_n_frame(cfg_n_frame), .msg_full(msg_full),
        .msg_valid(msg_valid), .msg(msg), .busy(busy), .done(done),
        .n_frame(n_frame), .cfg_err(cfg_err)
    );

    always #5 clk = ~clk;

    int          n_tests = 0;
    int          n_fail = 0;
    logic [31:0] sb_q[$];
    int          cyc = 0;
    logic        full_s = 1'b0;
    int          valid_cnt, first_cyc, last_cyc, done_seen, done_cyc;
    logic [31:0] last_msg = '0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] word(input bit fv, input bit lv, input int dn);
        logic [31:0] w;
        w = ((dn % 4096) << 8) | (32'(fv) << 5) | (32'(lv) << 4);
        return w;
    endfunction

    task automatic push_run(input int ncol, input int nrow, input int ilg, input int ifg, input int nfr);
        int ge, gl;
        ge = (ifg == 0) ? 1 : ifg;
        gl = (ilg == 0) ? 1 : ilg;
        repeat (ge) sb_q.push_back(word(0, 0, 0));
        for (int f = 0; f < nfr; f++) begin
            for (int r = 0; r < nrow; r++) begin
                for (int c = 0; c < ncol; c++) sb_q.push_back(word(1, 1, f + r + c));
                if (r < nrow - 1) repeat (gl) sb_q.push_back(word(1, 0, 0));
            end
            repeat (ge) sb_q.push_back(word(0, 0, 0));
        end
    endtask

    always @(posedge clk) begin
        cyc    <= cyc + 1;
        full_s <= msg_full;
    end

    always @(negedge clk) begin
        if (full_s && reset) begin
            check("stall_valid", msg_valid, 0);
            check("stall_hold", msg, last_msg);
        end
        if (msg_valid) begin
            if (sb_q.size() == 0) check("sb_underflow", sb_q.size(), 1);
            else check("word", msg, sb_q.pop_front());
            valid_cnt++;
            if (first_cyc < 0) first_cyc = cyc;
            last_cyc = cyc;
            last_msg = msg;
        end
        if (done) begin
            done_seen++;
            done_cyc = cyc;
        end
    end

    task automatic start_run(input int ncol, input int nrow, input int ilg, input int ifg,
                             input int nfr, input bit with_stop, input bit expect_busy);
        @(negedge clk);
        valid_cnt = 0; first_cyc = -1; last_cyc = -1; done_seen = 0; done_cyc = -1;
        cfg_n_col = COL_W'(ncol); cfg_n_row = ROW_W'(nrow);
        cfg_ilg = 8'(ilg); cfg_ifg = 8'(ifg); cfg_n_frame = 20'(nfr);
        start = 1'b1; stop = with_stop;
        @(negedge clk);
        start = 1'b0; stop = 1'b0;
        check("busy_start", busy, expect_busy);
    endtask

    task automatic wait_count(input int n);
        for (int i = 0; i < 2000 && valid_cnt < n; i++) @(negedge clk);
        if (valid_cnt < n) check("wait_count", valid_cnt, n);
    endtask

    task automatic finish_run(input int exp_words, input int exp_nfr, input int stall);
        for (int i = 0; i < 8000 && done_seen == 0; i++) @(negedge clk);
        check("done_seen", done_seen != 0, 1);
        check("word_count", valid_cnt, exp_words);
        check("sb_empty", sb_q.size(), 0);
        check("contiguous", last_cyc - first_cyc, exp_words - 1 + stall);
        check("done_latency", done_cyc - last_cyc, 1);
        check("n_frame", n_frame, exp_nfr);
        check("busy_after", busy, 0);
        @(negedge clk);
        check("done_pulse", done, 0);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check("rst_valid", msg_valid, 0);
        check("rst_msg", msg, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_nframe", n_frame, 0);
        check("rst_cfgerr", cfg_err, 0);
        reset = 1'b1;

        // basic single frame
        push_run(4, 2, 2, 3, 1);
        start_run(4, 2, 2, 3, 1, 0, 1);
        finish_run(16, 1, 0);

        // 5-cycle backpressure in the middle of line 0
        push_run(4, 2, 2, 3, 1);
        start_run(4, 2, 2, 3, 1, 0, 1);
        wait_count(5);
        msg_full = 1'b1;
        repeat (5) @(negedge clk);
        msg_full = 1'b0;
        finish_run(16, 1, 5);

        // continuous mode, stop during frame 2 row 0
        push_run(4, 2, 2, 3, 3);
        start_run(4, 2, 2, 3, 0, 0, 1);
        wait_count(30);
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        finish_run(3 + 13 * 3, 3, 0);

        // start and stop together: stop ignored, both frames sent
        push_run(2, 1, 1, 1, 2);
        start_run(2, 1, 1, 1, 2, 1, 1);
        finish_run(7, 2, 0);

        // zero gaps behave as one word
        push_run(2, 1, 0, 0, 1);
        start_run(2, 1, 0, 0, 1, 0, 1);
        finish_run(4, 1, 0);

        // invalid config rejected, then a valid run
        start_run(0, 2, 2, 3, 1, 0, 0);
        repeat (5) @(negedge clk);
        check("cfgerr_set", cfg_err, 1);
        check("cfgerr_busy", busy, 0);
        check("cfgerr_novalid", valid_cnt, 0);
        push_run(4, 2, 2, 3, 1);
        start_run(4, 2, 2, 3, 1, 0, 1);
        finish_run(16, 1, 0);

        // wide line: DN wraps 4095 -> 0
        push_run(4097, 1, 1, 1, 1);
        start_run(4097, 1, 1, 1, 1, 0, 1);
        finish_run(4099, 1, 0);

        // reset mid-line then a fresh run
        push_run(4, 2, 2, 3, 1);
        start_run(4, 2, 2, 3, 1, 0, 1);
        wait_count(5);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1 sb_q.delete();
        @(negedge clk);
        check("midrst_valid", msg_valid, 0);
        check("midrst_busy", busy, 0);
        check("midrst_msg", msg, 0);
        check("midrst_nframe", n_frame, 0);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        check("midrst_idle", valid_cnt >= 5 && !msg_valid, 1);
        push_run(4, 2, 2, 3, 1);
        start_run(4, 2, 2, 3, 1, 0, 1);
        finish_run(16, 1, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
